// File: rtl/leaf_user_rx_buffer.sv
// Elastic rx buffer: FWFT FIFO between leaf interface and user kernel, with occupancy/peak readback.
// Latency one cycle write-to-dout; ack_out = !full from registered count only, independent of ack_in.
module leaf_user_rx_buffer #(
  parameter int PAYLOAD_BITS = 32,
  parameter int DEPTH_BITS   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [PAYLOAD_BITS-1:0] din,
  input  logic                    vld_in,
  output logic                    ack_out,
  output logic [PAYLOAD_BITS-1:0] dout,
  output logic                    vld_out,
  input  logic                    ack_in,
  output logic [DEPTH_BITS:0]     count,
  output logic [DEPTH_BITS:0]     peak,
  output logic                    full,
  output logic                    empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [DEPTH_BITS:0] ONE_CNT  = {{DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [DEPTH_BITS-1:0] ONE_PTR = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];

  logic [DEPTH_BITS-1:0] wptr_q, wptr_d;
  logic [DEPTH_BITS-1:0] rptr_q, rptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic [DEPTH_BITS:0]   peak_q, peak_d;

  logic wr_en;
  logic rd_en;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign ack_out = !full;
  assign vld_out = !empty;
  assign dout    = mem[rptr_q];
  assign count   = count_q;
  assign peak    = peak_q;

  assign wr_en = vld_in && ack_out;
  assign rd_en = vld_out && ack_in;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    peak_d  = peak_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      peak_d  = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + ONE_PTR;
      if (rd_en) rptr_d = rptr_q + ONE_PTR;
      if (wr_en && !rd_en)      count_d = count_q + ONE_CNT;
      else if (rd_en && !wr_en) count_d = count_q - ONE_CNT;
      // count never exceeds depth, so peak saturates on its own
      if (count_d > peak_q) peak_d = count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      peak_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      peak_q  <= peak_d;
    end
  end

  // Storage is deliberately unreset so it maps onto LUTRAM.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) mem[wptr_q] <= din;
  end

endmodule

// File: tb/tb_leaf_user_rx_buffer.sv
// Bench for leaf_user_rx_buffer: directed scenarios plus random traffic against a queue model.
module tb_leaf_user_rx_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic [31:0] din;
  logic        vld_in;
  logic        ack_out;
  logic [31:0] dout;
  logic        vld_out;
  logic        ack_in;
  logic [4:0]  count;
  logic [4:0]  peak;
  logic        full;
  logic        empty;

  leaf_user_rx_buffer #(.PAYLOAD_BITS(32), .DEPTH_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .din(din), .vld_in(vld_in), .ack_out(ack_out),
    .dout(dout), .vld_out(vld_out), .ack_in(ack_in),
    .count(count), .peak(peak), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq [$];
  int unsigned mpeak;
  bit          last_hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    int n;
    n = mq.size();
    chk("count", 64'(count), 64'(n));
    chk("peak", 64'(peak), 64'(mpeak));
    chk("full", 64'(full), 64'(n == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("ack_out", 64'(ack_out), 64'(n != DEPTH));
    chk("vld_out", 64'(vld_out), 64'(n != 0));
    if (n != 0) chk("dout", 64'(dout), 64'(mq[0]));
  endtask

  // One clock: decide transfers from pre-edge state, then update the model and compare.
  task automatic cycle();
    bit wr, rd;
    wr = vld_in && (mq.size() < DEPTH);
    rd = ack_in && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (clear) begin
      mq.delete();
      mpeak = 0;
    end else begin
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(din);
      if (mq.size() > mpeak) mpeak = mq.size();
    end
    last_hs = wr;
    compare_model();
  endtask

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    din     = '0;
    vld_in  = 1'b0;
    ack_in  = 1'b0;
    mpeak   = 0;
    last_hs = 1'b0;
    #2;
    chk("rst_ack_out", 64'(ack_out), 64'd1);
    chk("rst_vld_out", 64'(vld_out), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_peak", 64'(peak), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    reset_n = 1'b1;

    // Fill to full, then offer a 17th word that must be held off.
    vld_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 32'h100 + 32'(i);
      cycle();
    end
    chk("fill_ack_out", 64'(ack_out), 64'd0);
    chk("fill_count", 64'(count), 64'd16);
    chk("fill_peak", 64'(peak), 64'd16);
    din = 32'h110;
    cycle();
    cycle();
    chk("hold17_count", 64'(count), 64'd16);
    chk("hold17_head", 64'(dout), 64'h100);

    // Drain in order.
    vld_in = 1'b0;
    ack_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_dout", 64'(dout), 64'(32'h100 + 32'(i)));
      cycle();
    end
    chk("drain_empty", 64'(empty), 64'd1);
    chk("drain_peak", 64'(peak), 64'd16);

    // Streaming at count 3 through many pointer wraps.
    ack_in = 1'b0;
    vld_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 32'h200 + 32'(i);
      cycle();
    end
    ack_in = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = $urandom;
      cycle();
      chk("stream_vld", 64'(vld_out), 64'd1);
      chk("stream_count", 64'(count), 64'd3);
    end

    // Simultaneous read and write while full: read only.
    ack_in = 1'b0;
    for (int i = 0; i < 13; i++) begin
      din = 32'h300 + 32'(i);
      cycle();
    end
    chk("pre_coll_full", 64'(full), 64'd1);
    ack_in = 1'b1;
    din = 32'h3AA;
    cycle();
    chk("coll_count15", 64'(count), 64'd15);
    ack_in = 1'b0;
    cycle();
    chk("coll_count16", 64'(count), 64'd16);

    // Clear colliding with a write and a read at count 5.
    vld_in = 1'b0;
    ack_in = 1'b1;
    for (int i = 0; i < 11; i++) cycle();
    chk("pre_clear_count", 64'(count), 64'd5);
    clear  = 1'b1;
    vld_in = 1'b1;
    din    = 32'hDEAD_BEEF;
    cycle();
    clear = 1'b0;
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_peak", 64'(peak), 64'd0);
    chk("clear_empty", 64'(empty), 64'd1);
    ack_in = 1'b0;
    din    = 32'h55;
    cycle();
    vld_in = 1'b0;
    chk("post_clear_dout", 64'(dout), 64'h55);

    // Random traffic; upstream holds din/vld_in until handshake.
    for (int seg = 0; seg < 2; seg++) begin
      for (int i = 0; i < 200; i++) begin
        clear = ($urandom_range(0, 49) == 0);
        if (!vld_in || last_hs) begin
          vld_in = (seg == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
          din    = $urandom;
        end
        ack_in = (seg == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
        cycle();
      end
    end
    clear = 1'b0;

    // Asynchronous reset between edges at count 7.
    clear  = 1'b1;
    vld_in = 1'b0;
    ack_in = 1'b0;
    cycle();
    clear  = 1'b0;
    vld_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      din = 32'h400 + 32'(i);
      cycle();
    end
    chk("pre_arst_count", 64'(count), 64'd7);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_vld_out", 64'(vld_out), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_ack_out", 64'(ack_out), 64'd1);
    chk("arst_peak", 64'(peak), 64'd0);
    mq.delete();
    mpeak = 0;
    vld_in = 1'b0;
    #2;
    reset_n = 1'b1;
    vld_in = 1'b1;
    din    = 32'h777;
    cycle();
    vld_in = 1'b0;
    ack_in = 1'b1;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
